collision_event_scheduler: RTL and testbench

Sits between the per-pixel collision detection and the game-logic FSM. Accumulates player-vs-object pixel overlaps over each VGA frame and snapshots them at startOfFrame. It then delivers one event per colliding object to game logic over a valid/ack handshake, in fixed priority order. Per-object hold-off suppresses repeated hits from a sprite that stays overlapped across consecutive frames.

---
 rtl/collision_event_scheduler_if.sv | 11 +
 rtl/collision_event_scheduler.sv | 98 +++++++++
 tb/tb_collision_event_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/collision_event_scheduler_if.sv
// Valid/ack event channel from the collision scheduler to the game-logic FSM.
interface collision_event_scheduler_if #(
    parameter int IDW = 2
);
    logic           event_valid;
    logic [IDW-1:0] event_id;
    logic           event_ack;

    modport master (output event_valid, output event_id, input event_ack);
    modport slave  (input event_valid, input event_id, output event_ack);
endinterface

// File: rtl/collision_event_scheduler.sv
// Accumulates player/object pixel overlaps per frame, snapshots them at startOfFrame
// and reports one event per colliding object in index order, with per-object hold-off.
module collision_event_scheduler #(
    parameter int NUM_OBJ        = 4,
    parameter int HOLDOFF_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 player_dr,
    input  logic [NUM_OBJ-1:0]   obj_dr,
    input  logic [NUM_OBJ-1:0]   obj_enable,
    collision_event_scheduler_if.master evt,
    output logic                 any_collision,
    output logic [7:0]           missed_events
);
    localparam int IDW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REPORT = 1'b1;

    logic [0:0]         state, state_nxt;
    logic [NUM_OBJ-1:0] hit_now, hit_pend, report, report_nxt;
    logic [NUM_OBJ-1:0] snapshot, ack_clr, dropped;
    logic [3:0]         holdoff [NUM_OBJ];
    logic [IDW-1:0]     low_id;
    logic               low_found, fire;
    logic [4:0]         drop_cnt;
    logic [8:0]         missed_sum;

    always_comb begin
        hit_now = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++)
            hit_now[i] = player_dr & obj_dr[i] & obj_enable[i] & (holdoff[i] == 4'd0);
    end

    // Lowest set report bit is the presented id; an ack clears exactly that bit.
    assign fire = (state == S_REPORT) & evt.event_ack;

    always_comb begin
        low_id    = '0;
        low_found = 1'b0;
        ack_clr   = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (report[i] && !low_found) begin
                low_id     = IDW'(i);
                low_found  = 1'b1;
                ack_clr[i] = fire;
            end
        end
    end

    assign snapshot = hit_pend & obj_enable;
    assign dropped  = report & obj_enable & ~ack_clr;

    always_comb begin
        drop_cnt = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++)
            drop_cnt = drop_cnt + 5'(dropped[i]);
    end

    assign missed_sum = {1'b0, missed_events} + 9'(drop_cnt);
    assign report_nxt = startOfFrame ? snapshot : (report & obj_enable & ~ack_clr);
    assign state_nxt  = (report_nxt != '0) ? S_REPORT : S_IDLE;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= S_IDLE;
            hit_pend      <= '0;
            report        <= '0;
            any_collision <= 1'b0;
            missed_events <= '0;
            for (int unsigned i = 0; i < NUM_OBJ; i++)
                holdoff[i] <= '0;
        end else begin
            state  <= state_nxt;
            report <= report_nxt;
            if (startOfFrame) begin
                hit_pend      <= hit_now;
                any_collision <= |hit_now;
                missed_events <= missed_sum[8] ? 8'hFF : missed_sum[7:0];
                // A fresh report reloads the counter in preference to decrementing it.
                for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                    if (snapshot[i] && (HOLDOFF_FRAMES != 0))
                        holdoff[i] <= 4'(HOLDOFF_FRAMES);
                    else if (holdoff[i] != 4'd0)
                        holdoff[i] <= holdoff[i] - 4'd1;
                end
            end else begin
                hit_pend      <= (hit_pend | hit_now) & obj_enable;
                any_collision <= any_collision | (|hit_now);
            end
        end
    end

    assign evt.event_valid = (state == S_REPORT);
    assign evt.event_id    = low_id;
endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler: one instance with hold-off 2, one with hold-off 0.
module tb_collision_event_scheduler;
    logic       clk;
    logic       resetN;
    logic       sof;
    logic       player_dr;
    logic [3:0] obj_dr;
    logic [3:0] obj_enable;
    logic       ack;
    logic       any_h2, any_h0;
    logic [7:0] missed_h2, missed_h0;
    int         checks;
    int         failures;
    logic [4:0] exp_h2, exp_h0;

    collision_event_scheduler_if #(.IDW(2)) bus  ();
    collision_event_scheduler_if #(.IDW(2)) bus0 ();

    assign bus.event_ack  = ack;
    assign bus0.event_ack = ack;

    collision_event_scheduler #(.NUM_OBJ(4), .HOLDOFF_FRAMES(2)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .player_dr(player_dr),
        .obj_dr(obj_dr), .obj_enable(obj_enable), .evt(bus.master),
        .any_collision(any_h2), .missed_events(missed_h2)
    );

    collision_event_scheduler #(.NUM_OBJ(4), .HOLDOFF_FRAMES(0)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .player_dr(player_dr),
        .obj_dr(obj_dr), .obj_enable(obj_enable), .evt(bus0.master),
        .any_collision(any_h0), .missed_events(missed_h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0; sof = 1'b0; player_dr = 1'b0; obj_dr = '0;
        obj_enable = 4'hF; ack = 1'b0;
        tick(); tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic hit(input logic [3:0] mask, input int n);
        player_dr = 1'b1; obj_dr = mask;
        repeat (n) tick();
        player_dr = 1'b0; obj_dr = '0;
    endtask

    task automatic sof_tick();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;

        // Reset state and single-object collision
        do_reset();
        chk("rst_valid", 32'(bus.event_valid), 0);
        chk("rst_id", 32'(bus.event_id), 0);
        chk("rst_any", 32'(any_h2), 0);
        chk("rst_missed", 32'(missed_h2), 0);
        ack = 1'b1;
        tick();
        chk("t1_ack_idle", 32'(bus.event_valid), 0);
        player_dr = 1'b1; obj_dr = 4'b0100;
        tick();
        chk("t1_any_rise", 32'(any_h2), 1);
        repeat (9) tick();
        player_dr = 1'b0; obj_dr = '0;
        sof_tick();
        chk("t1_valid", 32'(bus.event_valid), 1);
        chk("t1_id", 32'(bus.event_id), 2);
        chk("t1_any_clr", 32'(any_h2), 0);
        tick();
        chk("t1_done", 32'(bus.event_valid), 0);

        // Three objects, back-to-back acks
        hit(4'b1011, 3);
        sof_tick();
        chk("t2_id0", 32'(bus.event_id), 0);
        chk("t2_v0", 32'(bus.event_valid), 1);
        tick();
        chk("t2_id1", 32'(bus.event_id), 1);
        tick();
        chk("t2_id3", 32'(bus.event_id), 3);
        tick();
        chk("t2_idle", 32'(bus.event_valid), 0);
        chk("t2_missed", 32'(missed_h2), 0);

        // Sustained overlap over five frames: hold-off 2 vs hold-off 0
        do_reset();
        ack = 1'b1;
        exp_h2 = 5'b01001;
        exp_h0 = 5'b11111;
        for (int f = 0; f < 5; f++) begin
            repeat (3) tick();
            hit(4'b0010, 4);
            repeat (2) tick();
            sof_tick();
            chk($sformatf("t3_h2_f%0d", f), 32'(bus.event_valid), 32'(exp_h2[f]));
            chk($sformatf("t3_h0_f%0d", f), 32'(bus0.event_valid), 32'(exp_h0[f]));
        end
        tick();

        // Overrun: unacked events dropped and counted
        do_reset();
        hit(4'b0101, 2);
        sof_tick();
        chk("t4_id0", 32'(bus.event_id), 0);
        tick(); tick();
        chk("t4_id_stable", 32'(bus.event_id), 0);
        hit(4'b1000, 1);
        tick();
        sof_tick();
        chk("t4_missed", 32'(missed_h2), 2);
        chk("t4_id3", 32'(bus.event_id), 3);

        // Hit in the startOfFrame cycle, plus ack in that same cycle
        ack = 1'b1; player_dr = 1'b1; obj_dr = 4'b0010;
        sof_tick();
        ack = 1'b0; player_dr = 1'b0; obj_dr = '0;
        chk("t5_missed_ack_sof", 32'(missed_h2), 2);
        chk("t5_not_in_snap", 32'(bus.event_valid), 0);
        chk("t5_any", 32'(any_h2), 1);
        repeat (3) tick();
        sof_tick();
        chk("t5_late_valid", 32'(bus.event_valid), 1);
        chk("t5_late_id", 32'(bus.event_id), 1);

        // Enable drop on the presented object, then asynchronous reset mid-report
        do_reset();
        hit(4'b0101, 1);
        sof_tick();
        chk("t6_id0", 32'(bus.event_id), 0);
        obj_enable = 4'b1110;
        tick();
        chk("t6_next_id", 32'(bus.event_id), 2);
        chk("t6_valid", 32'(bus.event_valid), 1);
        chk("t6_missed", 32'(missed_h2), 0);
        hit(4'b1000, 1);
        sof_tick();
        hit(4'b0010, 1);
        chk("t6_pre_missed", 32'(missed_h2), 1);
        chk("t6_pre_id", 32'(bus.event_id), 3);
        chk("t6_pre_any", 32'(any_h2), 1);
        #2 resetN = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.event_valid), 0);
        chk("t6_rst_id", 32'(bus.event_id), 0);
        chk("t6_rst_any", 32'(any_h2), 0);
        chk("t6_rst_missed", 32'(missed_h2), 0);

        // missed_events saturation on the hold-off 0 instance
        do_reset();
        for (int n = 1; n <= 130; n++) begin
            hit(4'b0011, 1);
            sof_tick();
            if (n == 128) chk("sat_254", 32'(missed_h0), 254);
            if (n == 129) chk("sat_255", 32'(missed_h0), 255);
        end
        chk("sat_hold", 32'(missed_h0), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
